// File: rtl/onchip_mem_fill_check.sv
// Avalon-MM initiator: pattern fill and/or read-back check of on-chip RAM.
// Ports: cmd_* command in, busy/done/err_* status out, mem_* Avalon master.
module onchip_mem_fill_check #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int MEM_DEPTH    = 9000,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic [1:0]          cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [ADDR_W-1:0]   cmd_count,
  input  logic [DATA_W-1:0]   cmd_seed,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   err_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int L    = READ_LATENCY;
  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_t;

  state_t state_q, state_n;

  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] off_q;
  logic [DATA_W-1:0] exp_q;

  logic [L-1:0]      pv_q;
  logic [ADDR_W-1:0] pa_q [L];
  logic [DATA_W-1:0] pd_q [L];

  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W-1:0] nxt_off;
  logic              last;
  logic              pend;

  logic              ld;
  logic              iss;
  logic              iss_wr;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] iss_off;
  logic [DATA_W-1:0] iss_pat;

  // Wrap by compare: MEM_DEPTH need not be a power of two.
  assign addr_inc = {1'b0, mem_address}
                  + (ADDR_W+1)'(1);
  assign nxt_addr = (addr_inc == DEPTH)
                  ? '0 : addr_inc[ADDR_W-1:0];
  assign nxt_off  = off_q + ADDR_W'(1);
  assign last     = (nxt_off == count_q);

  // Reads still in flight ahead of the output stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < L - 1; i++)
      pend = pend | pv_q[i];
  end

  always_comb begin
    state_n  = state_q;
    ld       = 1'b0;
    iss      = 1'b0;
    iss_wr   = 1'b0;
    iss_addr = '0;
    iss_off  = '0;
    iss_pat  = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          ld = 1'b1;
          if (cmd_count == '0 ||
              cmd_mode == 2'd3) begin
            state_n = DONE;
          end else begin
            iss      = 1'b1;
            iss_wr   = (cmd_mode != 2'd1);
            iss_addr = cmd_base;
            iss_pat  = cmd_seed;
            state_n  = (cmd_mode == 2'd1)
                     ? READ : WRITE;
          end
        end
      end
      WRITE: begin
        if (!last) begin
          iss      = 1'b1;
          iss_wr   = 1'b1;
          iss_addr = nxt_addr;
          iss_off  = nxt_off;
          iss_pat  = exp_q + DATA_W'(1);
        end else if (mode_q == 2'd2) begin
          iss      = 1'b1;
          iss_addr = base_q;
          iss_pat  = seed_q;
          state_n  = READ;
        end else begin
          state_n  = DONE;
        end
      end
      READ: begin
        if (!last) begin
          iss      = 1'b1;
          iss_addr = nxt_addr;
          iss_off  = nxt_off;
          iss_pat  = exp_q + DATA_W'(1);
        end else begin
          state_n  = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mode_q          <= '0;
      base_q          <= '0;
      count_q         <= '0;
      seed_q          <= '0;
      off_q           <= '0;
      exp_q           <= '0;
      mem_chipselect  <= 1'b0;
      mem_write       <= 1'b0;
      mem_byteenable  <= '0;
      mem_address     <= '0;
      mem_writedata   <= '0;
      pv_q            <= '0;
      for (int i = 0; i < L; i++) begin
        pa_q[i] <= '0;
        pd_q[i] <= '0;
      end
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      state_q        <= state_n;
      mem_chipselect <= iss;
      mem_write      <= iss & iss_wr;
      mem_byteenable <= {BE_W{iss}};
      mem_address    <= iss_addr;
      mem_writedata  <= (iss & iss_wr)
                      ? iss_pat : '0;
      exp_q          <= iss_pat;
      off_q          <= iss_off;
      if (ld) begin
        mode_q  <= cmd_mode;
        base_q  <= cmd_base;
        count_q <= cmd_count;
        seed_q  <= cmd_seed;
      end
      // Expected word rides along with each read.
      pv_q[0] <= mem_chipselect & ~mem_write;
      pa_q[0] <= mem_address;
      pd_q[0] <= exp_q;
      for (int i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      if (ld) begin
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
      end else if (pv_q[L-1] &&
                   mem_readdata != pd_q[L-1]) begin
        if (err_count != '1)
          err_count <= err_count + ADDR_W'(1);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= pa_q[L-1];
        end
      end
    end
  end

  assign busy = (state_q == WRITE) ||
                (state_q == READ)  ||
                (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_onchip_mem_fill_check.sv
// Bench for onchip_mem_fill_check: two instances (read latency 1 and 2)
// share commands; each has its own RAM model, access and done scoreboard.
module tb_onchip_mem_fill_check;

  localparam int D = 9000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [1:0]  cmd_mode;
  logic [13:0] cmd_base;
  logic [13:0] cmd_count;
  logic [31:0] cmd_seed;

  logic        busy [2];
  logic        done [2];
  logic        fev  [2];
  logic        cs   [2];
  logic        wr   [2];
  logic [13:0] errc [2];
  logic [13:0] fea  [2];
  logic [13:0] addr [2];
  logic [3:0]  be   [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];

  always #5 clk = ~clk;

  onchip_mem_fill_check #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .cmd_seed(cmd_seed),
    .busy(busy[0]), .done(done[0]),
    .err_count(errc[0]),
    .first_err_valid(fev[0]),
    .first_err_addr(fea[0]),
    .mem_address(addr[0]),
    .mem_byteenable(be[0]),
    .mem_chipselect(cs[0]),
    .mem_write(wr[0]),
    .mem_writedata(wd[0]),
    .mem_readdata(rd[0])
  );

  onchip_mem_fill_check #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .cmd_seed(cmd_seed),
    .busy(busy[1]), .done(done[1]),
    .err_count(errc[1]),
    .first_err_valid(fev[1]),
    .first_err_addr(fea[1]),
    .mem_address(addr[1]),
    .mem_byteenable(be[1]),
    .mem_chipselect(cs[1]),
    .mem_write(wr[1]),
    .mem_writedata(wd[1]),
    .mem_readdata(rd[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models, with a preload port for the stimulus thread.
  logic [31:0] ram [2][D];
  logic [31:0] rq1 [2];
  logic [31:0] rq2;
  logic        pl_en;
  int          pl_b, pl_n, pl_bad0, pl_bad1;
  logic [31:0] pl_s;

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (pl_en)
        for (int i = 0; i < pl_n; i++)
          ram[j][(pl_b + i) % D] <= (pl_s + 32'(i)) ^
            ((((pl_b + i) % D) == pl_bad0 ||
              ((pl_b + i) % D) == pl_bad1)
             ? 32'h1 : 32'h0);
      if (int'(addr[j]) < D) begin
        if (cs[j] === 1'b1 && wr[j] === 1'b1)
          ram[j][addr[j]] <= wd[j];
        rq1[j] <= ram[j][addr[j]];
      end
    end
    rq2 <= rq1[1];
  end

  assign rd[0] = rq1[0];
  assign rd[1] = rq2;

  typedef struct {
    int          inst;
    int          cyc;
    bit          wr;
    int          a;
    logic [31:0] d;
  } acc_t;

  typedef struct {
    int inst;
    int cyc;
    int err;
    bit fev;
    int fea;
  } dn_t;

  typedef struct {
    logic [1:0]  mode;
    int          base;
    int          cnt;
    logic [31:0] seed;
    bit          pre;
    int          bad0;
    int          bad1;
    int          e_err;
    bit          e_fev;
    int          e_fea;
  } vec_t;

  acc_t sbq [$];
  dn_t  dq  [$];
  vec_t tbl [7];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, longint act,
                     longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h",
                  nm, act, exp);
  endtask

  // Access / done monitor.
  int   mix;
  acc_t me;
  dn_t  md;
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (cs[j] === 1'b1) begin
        mix = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (mix < 0 && sbq[i].inst == j) mix = i;
        if (mix < 0) begin
          chk($sformatf("L%0d_spurious_access", j+1),
              longint'(addr[j]), -1);
        end else begin
          me = sbq[mix];
          sbq.delete(mix);
          chk($sformatf("L%0d_acc_cycle", j+1),
              cyc, me.cyc);
          chk($sformatf("L%0d_acc_write", j+1),
              longint'(wr[j]), longint'(me.wr));
          chk($sformatf("L%0d_acc_addr", j+1),
              longint'(addr[j]), me.a);
          chk($sformatf("L%0d_acc_be", j+1),
              longint'(be[j]), 4'hF);
          if (me.wr)
            chk($sformatf("L%0d_acc_wdata", j+1),
                longint'(wd[j]), longint'(me.d));
        end
      end
      if (done[j] === 1'b1) begin
        mix = -1;
        for (int i = 0; i < dq.size(); i++)
          if (mix < 0 && dq[i].inst == j) mix = i;
        if (mix < 0) begin
          chk($sformatf("L%0d_spurious_done", j+1),
              cyc, -1);
        end else begin
          md = dq[mix];
          dq.delete(mix);
          chk($sformatf("L%0d_done_cycle", j+1),
              cyc, md.cyc);
          chk($sformatf("L%0d_done_busy", j+1),
              longint'(busy[j]), 0);
          chk($sformatf("L%0d_err_count", j+1),
              longint'(errc[j]), md.err);
          chk($sformatf("L%0d_first_err_valid", j+1),
              longint'(fev[j]), longint'(md.fev));
          chk($sformatf("L%0d_first_err_addr", j+1),
              longint'(fea[j]), md.fea);
        end
      end
    end
  end

  task automatic push_acc(int j, int c, bit w,
                          int a, logic [31:0] d);
    acc_t e;
    e.inst = j; e.cyc = c; e.wr = w;
    e.a = a; e.d = d;
    sbq.push_back(e);
  endtask

  task automatic push_cmd(int k, logic [1:0] m,
                          int b, int n,
                          logic [31:0] s, int ee,
                          bit ef, int ea);
    dn_t dn;
    int  rs;
    for (int j = 0; j < 2; j++) begin
      if (n != 0 && m != 2'd3) begin
        if (m != 2'd1)
          for (int i = 0; i < n; i++)
            push_acc(j, k + 1 + i, 1'b1,
                     (b + i) % D, s + 32'(i));
        if (m != 2'd0) begin
          rs = (m == 2'd2) ? k + n + 1 : k + 1;
          for (int i = 0; i < n; i++)
            push_acc(j, rs + i, 1'b0,
                     (b + i) % D, s + 32'(i));
        end
      end
      dn.inst = j;
      dn.err  = ee;
      dn.fev  = ef;
      dn.fea  = ea;
      if (n == 0 || m == 2'd3) dn.cyc = k + 1;
      else if (m == 2'd0)      dn.cyc = k + n + 1;
      else if (m == 2'd1)      dn.cyc = k + n + j + 2;
      else                     dn.cyc = k + 2*n + j + 2;
      dq.push_back(dn);
    end
  endtask

  task automatic issue(logic [1:0] m, int b, int n,
                       logic [31:0] s, bit push,
                       int ee, bit ef, int ea,
                       output int k);
    @(negedge clk);
    k = cyc;
    if (push) push_cmd(k, m, b, n, s, ee, ef, ea);
    cmd_mode  = m;
    cmd_base  = 14'(b);
    cmd_count = 14'(n);
    cmd_seed  = s;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic preload(int b, int n,
                         logic [31:0] s,
                         int bad0, int bad1);
    @(negedge clk);
    pl_b = b; pl_n = n; pl_s = s;
    pl_bad0 = bad0; pl_bad1 = bad1;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int t = 0;
    while ((sbq.size() != 0 || dq.size() != 0)
           && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sbq.size() + dq.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s_L%0d_cs", tag, j+1),
          longint'(cs[j]), 0);
      chk($sformatf("%s_L%0d_busy", tag, j+1),
          longint'(busy[j]), 0);
      chk($sformatf("%s_L%0d_done", tag, j+1),
          longint'(done[j]), 0);
      chk($sformatf("%s_L%0d_err", tag, j+1),
          longint'(errc[j]), 0);
      chk($sformatf("%s_L%0d_fev", tag, j+1),
          longint'(fev[j]), 0);
      chk($sformatf("%s_L%0d_fea", tag, j+1),
          longint'(fea[j]), 0);
      chk($sformatf("%s_L%0d_addr", tag, j+1),
          longint'(addr[j]), 0);
      chk($sformatf("%s_L%0d_we", tag, j+1),
          longint'({wr[j], be[j]}), 0);
      chk($sformatf("%s_L%0d_wdata", tag, j+1),
          longint'(wd[j]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0] = '{2'd0, 0,    16, 32'h1000_0000,
               1'b0, -1,   -1,   0, 1'b0, 0};
    tbl[1] = '{2'd2, 8990, 20, 32'hA5A5_0000,
               1'b0, -1,   -1,   0, 1'b0, 0};
    tbl[2] = '{2'd1, 0,    10, 32'h0,
               1'b1, 5,    7,    2, 1'b1, 5};
    tbl[3] = '{2'd0, 0,    0,  32'h1234,
               1'b0, -1,   -1,   0, 1'b0, 0};
    tbl[4] = '{2'd3, 3,    5,  32'h9,
               1'b0, -1,   -1,   0, 1'b0, 0};
    tbl[5] = '{2'd2, 50,   4,  32'hFFFF_FFFE,
               1'b0, -1,   -1,   0, 1'b0, 0};
    tbl[6] = '{2'd1, 8998, 4,  32'h55,
               1'b1, 8999, 1,    2, 1'b1, 8999};

    reset = 1'b1; cmd_start = 1'b0;
    cmd_mode = '0; cmd_base = '0;
    cmd_count = '0; cmd_seed = '0;
    pl_en = 1'b0; pl_b = 0; pl_n = 0;
    pl_s = '0; pl_bad0 = -1; pl_bad1 = -1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].pre)
        preload(tbl[v].base, tbl[v].cnt,
                tbl[v].seed, tbl[v].bad0,
                tbl[v].bad1);
      issue(tbl[v].mode, tbl[v].base, tbl[v].cnt,
            tbl[v].seed, 1'b1, tbl[v].e_err,
            tbl[v].e_fev, tbl[v].e_fea, k);
      wait_drain(200);
      if (v == 0)
        for (int j = 0; j < 2; j++)
          for (int i = 0; i < 16; i++)
            chk($sformatf("L%0d_ram_%0d", j+1, i),
                longint'(ram[j][i]),
                longint'(32'h1000_0000 + 32'(i)));
    end

    repeat (5) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("L%0d_hold_err", j+1),
          longint'(errc[j]), 2);
      chk($sformatf("L%0d_hold_fev", j+1),
          longint'(fev[j]), 1);
      chk($sformatf("L%0d_hold_fea", j+1),
          longint'(fea[j]), 8999);
    end

    // cmd_start while busy and while done must be ignored.
    issue(2'd0, 100, 8, 32'hC0DE_0000, 1'b1,
          0, 1'b0, 0, k);
    while (cyc < k + 3) @(negedge clk);
    cmd_mode = 2'd1; cmd_base = 14'd200;
    cmd_count = 14'd3; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    while (cyc < k + 9) @(negedge clk);
    cmd_mode = 2'd0; cmd_base = 14'd300;
    cmd_count = 14'd2; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_drain(100);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("L%0d_ignored_busy", j+1),
          longint'(busy[j]), 0);
      chk($sformatf("L%0d_ignored_cs", j+1),
          longint'(cs[j]), 0);
    end

    // Reset after three writes of a ten-word fill.
    issue(2'd0, 0, 10, 32'h77, 1'b0, 0, 1'b0, 0, k);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 3; i++)
        push_acc(j, k + 1 + i, 1'b1, i,
                 32'h77 + 32'(i));
    while (cyc < k + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pending", sbq.size() + dq.size(), 0);
    issue(2'd0, 20, 4, 32'hBEEF_0000, 1'b1,
          0, 1'b0, 0, k);
    wait_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/onchip_mem_fill_check.md
Name: onchip_mem_fill_check

Overview:
- Avalon-MM initiator (master) that drives the single-port on-chip RAM slave in the Nios II subsystem (14-bit word address, 32-bit data, 4-bit byteenable).
- Fills a word range with a deterministic pattern and/or reads the range back and compares it, counting mismatches.
- Used for power-on memory test and for scrubbing the buffer before firmware use.
- Sits between a control/status register block, which issues commands, and the RAM's Avalon slave port.

Parameters:
- ADDR_W, 14, word address width; also the width of the count and error-count fields.
- DATA_W, 32, data width. byteenable width is DATA_W/8.
- MEM_DEPTH, 9000, number of words in the RAM. Addresses wrap modulo MEM_DEPTH.
- READ_LATENCY, 1, cycles from read address to valid mem_readdata. Legal values are 1 and 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle command strobe; sampled only in IDLE.
- cmd_mode  in  2  0 = fill, 1 = check, 2 = fill-then-check, 3 = reserved.
- cmd_base  in  ADDR_W  first word address; must be < MEM_DEPTH.
- cmd_count  in  ADDR_W  number of words to process.
- cmd_seed  in  DATA_W  pattern seed.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse on command completion.
- err_count  out  ADDR_W  number of mismatches; saturating.
- first_err_valid  out  1  a mismatch has been recorded.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- mem_address  out  ADDR_W  Avalon address.
- mem_byteenable  out  DATA_W/8  always all ones when chipselect is high.
- mem_chipselect  out  1  access valid.
- mem_write  out  1  1 = write, 0 = read (when chipselect is high).
- mem_writedata  out  DATA_W  write data.
- mem_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after the read address.

Behaviour:
- Reset: all outputs are 0, state is IDLE; err_count, first_err_valid and first_err_addr are cleared.
- Reset mid-operation aborts the command at that clock edge. No done pulse; chipselect is low in the next cycle.
- All mem_* outputs are registered. The slave never stalls (no waitrequest), so one access is issued per cycle.
- Pattern: word i (0-based offset) = cmd_seed + i, modulo 2^DATA_W.
- Address: word i is at (cmd_base + i) mod MEM_DEPTH. Wrap is done by compare-and-reset, not by a power-of-two mask.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - cmd_start latches mode, base, count and seed, and clears the error outputs.
  - If count = 0 or mode = 3, go to DONE with no accesses.
  - Else go to WRITE (mode 0 or 2) or READ (mode 1).
- WRITE:
  - Issue a write each cycle, with chipselect = write = 1.
  - After word count-1: mode 0 goes to DONE; mode 2 goes to READ with the offset reset to 0.
- READ:
  - Issue a read each cycle, with chipselect = 1 and write = 0.
  - A READ_LATENCY-deep valid pipeline carries the expected data and address of each read.
  - After word count-1, go to DRAIN.
- DRAIN: wait until the valid pipeline is empty, then go to DONE.
- Compare: when the pipeline output is valid and mem_readdata differs from the expected data:
  - err_count increments, saturating at 2^ADDR_W-1.
  - On the first mismatch only, set first_err_valid and capture first_err_addr.
- DONE: done = 1 for exactly one cycle with busy = 0, then IDLE.
- Timing: if cmd_start is sampled at edge k, busy is high from cycle k+1.
  - Fill of N words: writes in cycles k+1 .. k+N; done in cycle k+N+1.
  - Check: reads in cycles k+1 .. k+N; done in cycle k+N+READ_LATENCY+1.
  - Fill-then-check: reads in cycles k+N+1 .. k+2N; done in cycle k+2N+READ_LATENCY+1.
  - Zero-count command: done in cycle k+1.
- cmd_start while busy or while done is high is ignored.
- Error outputs hold their values until the next accepted command.

Test Plan:
- Fill: base=0, count=16, seed=0x1000_0000, mode 0 -> 16 consecutive writes, addresses 0..15, data 0x1000_0000..0x1000_000F; done 17 cycles after start; RAM model contents match.
- Fill-then-check, clean RAM model: base=8990, count=20 -> addresses 8990..8999 then 0..9 (wrap at MEM_DEPTH); err_count=0; first_err_valid=0; done at cycle 2N+L+1.
- Check with faults: RAM model corrupts addresses 5 and 7, mode 1, base=0, count=10, seed=0 -> err_count=2, first_err_addr=5, first_err_valid=1.
- Boundaries: count=0 -> done at k+1 with no chipselect; mode=3 -> same; cmd_start while busy -> ignored, with no change to the access sequence.
- Reset mid-fill after 3 writes -> chipselect is 0 the next cycle, all outputs 0, no done pulse; a new command then runs normally.
- READ_LATENCY=2, and a seed of 0xFFFF_FFFE with count 4 -> the data wraps to 0x0000_0001; compares are aligned and err_count=0.
